// File: rtl/team_06_tremolo_v2.sv
// Tremolo: amplitude modulation of an offset-binary sample stream by a triangle LFO.
// Optional square-wave LFO shape is enabled by defining TEAM_06_TREMOLO_SQUARE_EN.
module team_06_tremolo_v2 #(
  parameter int W        = 8,
  parameter int LFO_BITS = 4,
  parameter int DIV_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sample_valid,
  input  logic [W-1:0]        audio_in,
  input  logic [DIV_W-1:0]    rate,
  input  logic [LFO_BITS:0]   depth,
`ifdef TEAM_06_TREMOLO_SQUARE_EN
  input  logic                shape,
`endif
  output logic [W-1:0]        audio_out,
  output logic                out_valid,
  output logic [LFO_BITS:0]   lfo_val
);

  // Stream handshake: sample_valid is a one-cycle strobe with no backpressure;
  // every strobe yields exactly one out_valid pulse on the following cycle.

  localparam int MID = 2 ** (W - 1);
  localparam int PW  = W + LFO_BITS + 2;
  localparam int LW  = 2 * LFO_BITS + 1;
  localparam logic [LFO_BITS:0] PEAK_V = {1'b1, {LFO_BITS{1'b0}}};

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [LFO_BITS:0]  lfo_q, lfo_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W:0]     cnt_inc, rate_c;
  logic               step;

  logic [LFO_BITS:0]  depth_c, lfo_eff, atten, gain;
  logic [LW-1:0]      prod_ld;
  logic signed [PW-1:0] s_w, g_w, prod_s, out_w;
  logic [W-1:0]       wet;

  // Prescaler: >= compare lets a rate lowered below cnt step on the next strobe.
  always_comb begin
    rate_c  = (rate == '0) ? (DIV_W + 1)'(1) : {1'b0, rate};
    cnt_inc = {1'b0, cnt_q} + (DIV_W + 1)'(1);
    step    = sample_valid && en && (cnt_inc >= rate_c);
    cnt_d   = cnt_q;
    if (sample_valid && en) begin
      cnt_d = step ? '0 : cnt_inc[DIV_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    lfo_d   = lfo_q;
    if (step) begin
      case (state_q)
        UP: begin
          lfo_d = lfo_q + 1'b1;
          if (lfo_d == PEAK_V) state_d = DOWN;
        end
        DOWN: begin
          lfo_d = lfo_q - 1'b1;
          if (lfo_d == '0) state_d = UP;
        end
        default: state_d = UP;
      endcase
    end
  end

  // Audio path works on the LFO value held before this cycle's step.
  always_comb begin
    depth_c = (depth > PEAK_V) ? PEAK_V : depth;
`ifdef TEAM_06_TREMOLO_SQUARE_EN
    if (shape) lfo_eff = (state_q == UP) ? PEAK_V : '0;
    else       lfo_eff = lfo_q;
`else
    lfo_eff = lfo_q;
`endif
    prod_ld = LW'(lfo_eff) * LW'(depth_c);
    atten   = (LFO_BITS + 1)'(prod_ld >> LFO_BITS);
    gain    = PEAK_V - atten;
    s_w     = $signed(PW'(audio_in)) - $signed(PW'(MID));
    g_w     = $signed(PW'(gain));
    prod_s  = s_w * g_w;
    out_w   = (prod_s >>> LFO_BITS) + $signed(PW'(MID));
    wet     = W'(out_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UP;
      lfo_q     <= '0;
      cnt_q     <= '0;
      audio_out <= W'(MID);
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfo_q     <= lfo_d;
      cnt_q     <= cnt_d;
      out_valid <= sample_valid;
      if (sample_valid) begin
        audio_out <= en ? wet : audio_in;
      end
    end
  end

  assign lfo_val = lfo_q;

endmodule

// File: tb/tb_team_06_tremolo_v2.sv
// Directed bench for team_06_tremolo_v2 (W=8, LFO_BITS=4): vector table plus corner sequences.
module tb_team_06_tremolo_v2;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sample_valid;
  logic [7:0]  audio_in;
  logic [15:0] rate;
  logic [4:0]  depth;
  logic        shape;
  logic [7:0]  audio_out;
  logic        out_valid;
  logic [4:0]  lfo_val;

  int tests_run;
  int tests_failed;

  team_06_tremolo_v2 #(.W(8), .LFO_BITS(4), .DIV_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .rate         (rate),
    .depth        (depth),
`ifdef TEAM_06_TREMOLO_SQUARE_EN
    .shape        (shape),
`endif
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .lfo_val      (lfo_val)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int lfo;
    int dep;
    int ain;
    int exp_out;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One strobe; returns on the negedge after the capturing posedge.
  task automatic strobe(input logic [7:0] a);
    @(negedge clk);
    audio_in     = a;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  function automatic int tri_exp(input int n);
    int p;
    p = n % 32;
    return (p <= 16) ? p : 32 - p;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; en = 1'b1; sample_valid = 1'b0; audio_in = '0;
    rate = 16'd1; depth = '0; shape = 1'b0;

    //                lfo dep  ain  expected
    vecs[0]  = '{ 0, 16, 200, 200};
    vecs[1]  = '{16, 16, 200, 128};
    vecs[2]  = '{16,  8,   0,  64};
    vecs[3]  = '{ 8, 16, 200, 164};
    vecs[4]  = '{ 8, 16,   0,  64};
    vecs[5]  = '{ 4, 16, 255, 223};
    vecs[6]  = '{ 5, 31, 100, 108};
    vecs[7]  = '{16, 20,   0, 128};
    vecs[8]  = '{ 3,  5,   1,   1};
    vecs[9]  = '{15, 15, 129, 128};
    vecs[10] = '{12, 16, 127, 127};
    vecs[11] = '{10,  0, 200, 200};

    // reset state
    #3;
    check("reset_audio_out", audio_out, 128);
    check("reset_out_valid", out_valid, 0);
    check("reset_lfo_val", lfo_val, 0);
    @(negedge clk);
    rst = 1'b0;

    // depth=0 passes audio through with latency 1, then out_valid drops
    strobe(8'd200);
    check("lat1_audio_out", audio_out, 200);
    check("lat1_out_valid", out_valid, 1);
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_audio_hold", audio_out, 200);

    // table: walk LFO to target with depth 0, then apply the vector
    foreach (vecs[i]) begin
      do_reset();
      rate = 16'd1; en = 1'b1; depth = '0;
      for (int k = 0; k < vecs[i].lfo; k++) strobe(8'd128);
      check($sformatf("vec%0d_lfo", i), lfo_val, vecs[i].lfo);
      depth = 5'(vecs[i].dep);
      strobe(8'(vecs[i].ain));
      check($sformatf("vec%0d_out", i), audio_out, vecs[i].exp_out);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
    end

    // LFO triangle sequence for rate=1 and rate=0
    for (int r = 0; r < 2; r++) begin
      do_reset();
      rate = (r == 0) ? 16'd1 : 16'd0; depth = '0;
      for (int k = 0; k < 40; k++) begin
        check($sformatf("tri_r%0d_k%0d", r, k), lfo_val, tri_exp(k));
        strobe(8'd128);
      end
    end

    // rate=3 steps every third strobe
    do_reset();
    rate = 16'd3;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("rate3_k%0d", k), lfo_val, k / 3);
      strobe(8'd128);
    end

    // lowering rate below cnt steps on the next strobe
    do_reset();
    rate = 16'd5;
    for (int k = 0; k < 3; k++) strobe(8'd128);
    check("rate_lower_before", lfo_val, 0);
    rate = 16'd2;
    strobe(8'd128);
    check("rate_lower_after", lfo_val, 1);

    // bypass holds lfo and cnt; resume continues from held state
    do_reset();
    rate = 16'd2; depth = 5'd16;
    for (int k = 0; k < 19; k++) strobe(8'd128);
    check("byp_pre_lfo", lfo_val, 9);
    en = 1'b0;
    strobe(8'd37);
    check("byp_audio", audio_out, 37);
    check("byp_valid", out_valid, 1);
    check("byp_lfo_hold", lfo_val, 9);
    en = 1'b1;
    strobe(8'd200);
    check("resume_audio", audio_out, 159);
    check("resume_lfo", lfo_val, 10);

    // async reset mid-run right after a strobe
    do_reset();
    rate = 16'd1; depth = '0;
    for (int k = 0; k < 9; k++) strobe(8'd128);
    check("mid_pre_lfo", lfo_val, 9);
    check("mid_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_audio", audio_out, 128);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_lfo", lfo_val, 0);
    @(negedge clk);
    rst = 1'b0;
    depth = 5'd16;
    strobe(8'd200);
    check("post_rst_audio", audio_out, 200);
    check("post_rst_lfo", lfo_val, 1);

    // sample_valid held for three cycles: one sample per cycle
    do_reset();
    rate = 16'd1; depth = 5'd16;
    @(negedge clk);
    audio_in = 8'd200; sample_valid = 1'b1;
    @(negedge clk);
    check("burst0_audio", audio_out, 200);
    check("burst0_valid", out_valid, 1);
    @(negedge clk);
    check("burst1_audio", audio_out, 195);
    check("burst1_valid", out_valid, 1);
    @(negedge clk);
    sample_valid = 1'b0;
    check("burst2_audio", audio_out, 191);
    check("burst2_valid", out_valid, 1);
    check("burst_lfo", lfo_val, 3);
    @(negedge clk);
    check("burst_end_valid", out_valid, 0);

`ifdef TEAM_06_TREMOLO_SQUARE_EN
    // square shape: full attenuation in UP, none in DOWN
    do_reset();
    rate = 16'd1; depth = 5'd16; shape = 1'b1;
    strobe(8'd255);
    check("sq_up_audio", audio_out, 128);
    for (int k = 0; k < 16; k++) strobe(8'd128);
    check("sq_lfo_peak", lfo_val, 15);
    strobe(8'd255);
    check("sq_down_audio", audio_out, 255);
    shape = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
